// File: rtl/logicnet_lut_layer_pipe_pkg.sv
// Shared types and helpers for the LogicNet LUT layer.
// The neuron table depth and the neuron-select width are derived here so
// that the top level, the interface and the RAM agree on them.
package logicnet_lut_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } lut_state_e;

    // Width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Number of entries in a table addressed by fanin bits.
    function automatic int lut_depth(input int fanin);
        return 1 << fanin;
    endfunction

    localparam int FANIN_DEFAULT = 8;
    localparam int DEPTH         = lut_depth(FANIN_DEFAULT);

endpackage

// File: rtl/logicnet_lut_layer_pipe_if.sv
// Bundle of the layer's data-in, data-out and table-config signals.
// The master side drives vectors and table writes; the slave side is the layer.
interface logicnet_lut_layer_pipe_if
    import logicnet_lut_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int FANIN       = 8,
    parameter int OUT_BITS    = 1
);
    localparam int NIDX_W = clog2_min1(NUM_NEURONS);

    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_NEURONS*FANIN-1:0]    in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data;
    logic                            cfg_we;
    logic [NIDX_W-1:0]               cfg_neuron;
    logic [FANIN-1:0]                cfg_addr;
    logic [OUT_BITS-1:0]             cfg_wdata;
    logic                            cfg_busy;

    modport master (
        output in_valid, in_data, out_ready,
        output cfg_we, cfg_neuron, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_data, cfg_busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        input  cfg_we, cfg_neuron, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_data, cfg_busy
    );
endinterface

// File: rtl/logicnet_lut_layer_pipe_ram.sv
// One neuron's truth table: a small distributed RAM with a synchronous
// write port and an asynchronous read port, so a lookup settles within
// the same cycle its address is presented.
module logicnet_lut_ram
    import logicnet_lut_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [lut_depth(ADDR_W)];

    // Table contents are never reset; they are cleared by the owner's sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/logicnet_lut_layer_pipe.sv
// One LogicNet layer built from NUM_NEURONS runtime-writable truth tables.
// After reset every table is swept to zero (one entry per cycle, all
// neurons in parallel); only then are lookups and config writes accepted.
// Build option SKID_BUF_EN: adds a 2-entry output skid buffer so in_ready
// is a plain register with no combinational path from out_ready.
module logicnet_lut_layer_pipe
    import logicnet_lut_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int FANIN       = 8,
    parameter int OUT_BITS    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    logicnet_lut_layer_pipe_if.slave bus
);
    localparam int NIDX_W = clog2_min1(NUM_NEURONS);
    localparam int OUT_W  = NUM_NEURONS * OUT_BITS;

    lut_state_e        state;
    lut_state_e        next_state;
    logic [FANIN-1:0]  clr_cnt;
    logic [OUT_W-1:0]  lut_out;

    // State register and clear-sweep counter; reset always restarts the sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Leave CLEAR once the last table entry has been written.
    always_comb begin
        next_state = state;
        if (state == CLEAR && clr_cnt == {FANIN{1'b1}}) begin
            next_state = RUN;
        end
    end

    assign bus.cfg_busy = (state == CLEAR);

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
        logic             we;
        logic [FANIN-1:0] waddr;
        logic [OUT_BITS-1:0] wdata;

        // Sweep owns the write port during CLEAR; config writes are dropped then.
        always_comb begin
            we    = 1'b0;
            waddr = bus.cfg_addr;
            wdata = bus.cfg_wdata;
            if (state == CLEAR) begin
                we    = 1'b1;
                waddr = clr_cnt;
                wdata = '0;
            end else if (bus.cfg_we && bus.cfg_neuron == NIDX_W'(n)) begin
                we = 1'b1;
            end
        end

        logicnet_lut_ram #(
            .ADDR_W (FANIN),
            .DATA_W (OUT_BITS)
        ) u_ram (
            .clk   (clk),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (bus.in_data[n*FANIN +: FANIN]),
            .rdata (lut_out[n*OUT_BITS +: OUT_BITS])
        );
    end

`ifdef SKID_BUF_EN
    logic             out_valid_q, out_valid_n;
    logic [OUT_W-1:0] out_data_q, out_data_n;
    logic             sk_valid_q, sk_valid_n;
    logic [OUT_W-1:0] sk_data_q, sk_data_n;
    logic             in_ready_q, in_ready_n;
    logic             accept;
    logic             pop;

    assign accept = bus.in_valid && in_ready_q;
    assign pop    = out_valid_q && bus.out_ready;

    // Output slot refills from the skid entry first so order is preserved.
    always_comb begin
        out_valid_n = out_valid_q;
        out_data_n  = out_data_q;
        sk_valid_n  = sk_valid_q;
        sk_data_n   = sk_data_q;
        if (!out_valid_q || pop) begin
            if (sk_valid_q) begin
                out_valid_n = 1'b1;
                out_data_n  = sk_data_q;
                sk_valid_n  = accept;
                if (accept) begin
                    sk_data_n = lut_out;
                end
            end else begin
                out_valid_n = accept;
                if (accept) begin
                    out_data_n = lut_out;
                end
            end
        end else if (accept) begin
            sk_valid_n = 1'b1;
            sk_data_n  = lut_out;
        end
        in_ready_n = (next_state == RUN) && !(out_valid_n && sk_valid_n);
    end

    // Output, skid and ready registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sk_valid_q  <= 1'b0;
            sk_data_q   <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_n;
            out_data_q  <= out_data_n;
            sk_valid_q  <= sk_valid_n;
            sk_data_q   <= sk_data_n;
            in_ready_q  <= in_ready_n;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
`else
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic             in_ready_c;

    assign in_ready_c = (state == RUN) && (!out_valid_q || bus.out_ready);

    // Single output register: load whenever the slot is free or being drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (in_ready_c) begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_data_q <= lut_out;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
`endif

endmodule
